// File: rtl/punc_control.sv
`default_nettype none
// ============================================================================
// Module   : punc_control
// Purpose  : Multi-cycle control FSM for the PUnC LC3 processor. Sequences
//            INIT -> FETCH -> DECODE -> EXECUTE [-> EXECUTE2] per instruction
//            and parks in HALT on opcode 1111.
// Ports    : clk, rst             clock / synchronous active-high reset
//            ir, nzp_match        instruction word and branch flag from datapath
//            pc_*, ir_*, dmem_*,  datapath load / clear / strobe / mux selects
//            rf_*, temp_ld, nzp_*,
//            alu_*
//            halted               high while parked in HALT
//            retire_count         number of completed instructions (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module punc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        nzp_match,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_sel,
    output logic        ir_ld,
    output logic        ir_clr,
    output logic        dmem_wr,
    output logic [1:0]  dmem_r_addr_sel,
    output logic [1:0]  dmem_w_addr_sel,
    output logic        rf_w_wr,
    output logic        rf_w_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_rp_addr_sel,
    output logic        temp_ld,
    output logic        nzp_ld,
    output logic        nzp_clr,
    output logic [1:0]  alu_sel,
    output logic        alu_in_a_sel,
    output logic        halted,
    output logic [15:0] retire_count
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] c_OP_BR   = 4'b0000;
    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_LD   = 4'b0010;
    localparam logic [3:0] c_OP_ST   = 4'b0011;
    localparam logic [3:0] c_OP_JSR  = 4'b0100;
    localparam logic [3:0] c_OP_AND  = 4'b0101;
    localparam logic [3:0] c_OP_LDR  = 4'b0110;
    localparam logic [3:0] c_OP_STR  = 4'b0111;
    localparam logic [3:0] c_OP_NOT  = 4'b1001;
    localparam logic [3:0] c_OP_LDI  = 4'b1010;
    localparam logic [3:0] c_OP_STI  = 4'b1011;
    localparam logic [3:0] c_OP_JMP  = 4'b1100;
    localparam logic [3:0] c_OP_LEA  = 4'b1110;
    localparam logic [3:0] c_OP_HALT = 4'b1111;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_retire;
    logic [3:0]  w_opcode;
    logic        w_indirect;
    logic        w_retire;
    logic        w_unused;

    assign w_opcode   = ir[15:12];
    assign w_indirect = (w_opcode == c_OP_LDI) || (w_opcode == c_OP_STI);
    // Operand fields are consumed by the datapath, not by the controller.
    assign w_unused   = ^{ir[10:6], ir[4:0]};

    // An instruction completes on the edge leaving its last execute cycle.
    assign w_retire   = !rst && (((r_state == S_EXEC) && !w_indirect) ||
                                 (r_state == S_EXEC2));

    assign retire_count = rst ? 16'd0 : r_retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_INIT;
            r_retire <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retire <= r_retire + 16'd1;
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        pc_ld           = 1'b0;
        pc_clr          = 1'b0;
        pc_inc          = 1'b0;
        pc_sel          = 2'b00;
        ir_ld           = 1'b0;
        ir_clr          = 1'b0;
        dmem_wr         = 1'b0;
        dmem_r_addr_sel = 2'b00;
        dmem_w_addr_sel = 2'b00;
        rf_w_wr         = 1'b0;
        rf_w_addr_sel   = 1'b0;
        rf_w_data_sel   = 2'b00;
        rf_rp_addr_sel  = 1'b0;
        temp_ld         = 1'b0;
        nzp_ld          = 1'b0;
        nzp_clr         = 1'b0;
        alu_sel         = 2'b00;
        alu_in_a_sel    = 1'b0;
        halted          = 1'b0;

        case (r_state)
            S_INIT: begin
                pc_clr  = 1'b1;
                ir_clr  = 1'b1;
                nzp_clr = 1'b1;
                w_next  = S_FETCH;
            end
            S_FETCH: begin
                dmem_r_addr_sel = 2'b00;
                ir_ld           = 1'b1;
                pc_inc          = 1'b1;
                w_next          = S_DECODE;
            end
            S_DECODE: begin
                w_next = (w_opcode == c_OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_opcode)
                    c_OP_ADD, c_OP_AND: begin
                        rf_rp_addr_sel = 1'b1;
                        alu_in_a_sel   = ir[5];
                        alu_sel        = (w_opcode == c_OP_ADD) ? 2'b01 : 2'b10;
                        rf_w_data_sel  = 2'b00;
                        rf_w_addr_sel  = 1'b1;
                        rf_w_wr        = 1'b1;
                        nzp_ld         = 1'b1;
                    end
                    c_OP_NOT: begin
                        alu_sel       = 2'b11;
                        rf_w_data_sel = 2'b00;
                        rf_w_addr_sel = 1'b1;
                        rf_w_wr       = 1'b1;
                        nzp_ld        = 1'b1;
                    end
                    c_OP_BR: begin
                        if (nzp_match) begin
                            pc_ld  = 1'b1;
                            pc_sel = 2'b00;
                        end
                    end
                    c_OP_JMP: begin
                        pc_ld  = 1'b1;
                        pc_sel = 2'b10;
                    end
                    c_OP_JSR: begin
                        // Link and jump share one edge; the datapath reads the
                        // old R7 so JSRR R7 targets the pre-link value.
                        rf_w_addr_sel = 1'b0;
                        rf_w_data_sel = 2'b11;
                        rf_w_wr       = 1'b1;
                        pc_ld         = 1'b1;
                        pc_sel        = ir[11] ? 2'b01 : 2'b10;
                    end
                    c_OP_LD, c_OP_LDR: begin
                        dmem_r_addr_sel = (w_opcode == c_OP_LD) ? 2'b01 : 2'b11;
                        rf_w_data_sel   = 2'b10;
                        rf_w_addr_sel   = 1'b1;
                        rf_w_wr         = 1'b1;
                        nzp_ld          = 1'b1;
                    end
                    c_OP_LEA: begin
                        rf_w_data_sel = 2'b01;
                        rf_w_addr_sel = 1'b1;
                        rf_w_wr       = 1'b1;
                        nzp_ld        = 1'b1;
                    end
                    c_OP_ST, c_OP_STR: begin
                        rf_rp_addr_sel  = 1'b0;
                        dmem_w_addr_sel = (w_opcode == c_OP_ST) ? 2'b00 : 2'b10;
                        dmem_wr         = 1'b1;
                    end
                    c_OP_LDI, c_OP_STI: begin
                        // First leg of indirection: fetch the pointer into Temp.
                        dmem_r_addr_sel = 2'b01;
                        temp_ld         = 1'b1;
                        w_next          = S_EXEC2;
                    end
                    default: begin
                        // Reserved opcode retires as a NOP.
                    end
                endcase
            end
            S_EXEC2: begin
                w_next = S_FETCH;
                if (w_opcode == c_OP_LDI) begin
                    dmem_r_addr_sel = 2'b10;
                    rf_w_data_sel   = 2'b10;
                    rf_w_addr_sel   = 1'b1;
                    rf_w_wr         = 1'b1;
                    nzp_ld          = 1'b1;
                end else begin
                    rf_rp_addr_sel  = 1'b0;
                    dmem_w_addr_sel = 2'b01;
                    dmem_wr         = 1'b1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_INIT;
            end
        endcase

        // Reset suppresses every strobe in the same cycle, so an aborted
        // instruction can never write; only the clears stay asserted.
        if (rst) begin
            pc_ld           = 1'b0;
            pc_inc          = 1'b0;
            pc_sel          = 2'b00;
            ir_ld           = 1'b0;
            dmem_wr         = 1'b0;
            dmem_r_addr_sel = 2'b00;
            dmem_w_addr_sel = 2'b00;
            rf_w_wr         = 1'b0;
            rf_w_addr_sel   = 1'b0;
            rf_w_data_sel   = 2'b00;
            rf_rp_addr_sel  = 1'b0;
            temp_ld         = 1'b0;
            nzp_ld          = 1'b0;
            alu_sel         = 2'b00;
            alu_in_a_sel    = 1'b0;
            halted          = 1'b0;
            pc_clr          = 1'b1;
            ir_clr          = 1'b1;
            nzp_clr         = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_punc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_punc_control
// Purpose  : Self-checking bench for punc_control. A cycle-level model
//            (instruction phase + opcode table) predicts every output each
//            cycle; selected cycles are also pinned to hand-written values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_punc_control;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_sel;
        logic       ir_ld;
        logic       ir_clr;
        logic       dmem_wr;
        logic [1:0] dmem_r_addr_sel;
        logic [1:0] dmem_w_addr_sel;
        logic       rf_w_wr;
        logic       rf_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_rp_addr_sel;
        logic       temp_ld;
        logic       nzp_ld;
        logic       nzp_clr;
        logic [1:0] alu_sel;
        logic       alu_in_a_sel;
        logic       halted;
    } ctl_t;

    localparam int c_INIT = 0;
    localparam int c_FETCH = 1;
    localparam int c_DECODE = 2;
    localparam int c_EXEC = 3;
    localparam int c_EXEC2 = 4;
    localparam int c_HALT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ir = 16'h0000;
    logic        nzp_match = 1'b0;
    logic        pc_ld, pc_clr, pc_inc, ir_ld, ir_clr, dmem_wr;
    logic [1:0]  pc_sel, dmem_r_addr_sel, dmem_w_addr_sel, rf_w_data_sel, alu_sel;
    logic        rf_w_wr, rf_w_addr_sel, rf_rp_addr_sel, temp_ld, nzp_ld, nzp_clr;
    logic        alu_in_a_sel, halted;
    logic [15:0] retire_count;

    punc_control dut (
        .clk             (clk),
        .rst             (rst),
        .ir              (ir),
        .nzp_match       (nzp_match),
        .pc_ld           (pc_ld),
        .pc_clr          (pc_clr),
        .pc_inc          (pc_inc),
        .pc_sel          (pc_sel),
        .ir_ld           (ir_ld),
        .ir_clr          (ir_clr),
        .dmem_wr         (dmem_wr),
        .dmem_r_addr_sel (dmem_r_addr_sel),
        .dmem_w_addr_sel (dmem_w_addr_sel),
        .rf_w_wr         (rf_w_wr),
        .rf_w_addr_sel   (rf_w_addr_sel),
        .rf_w_data_sel   (rf_w_data_sel),
        .rf_rp_addr_sel  (rf_rp_addr_sel),
        .temp_ld         (temp_ld),
        .nzp_ld          (nzp_ld),
        .nzp_clr         (nzp_clr),
        .alu_sel         (alu_sel),
        .alu_in_a_sel    (alu_in_a_sel),
        .halted          (halted),
        .retire_count    (retire_count)
    );

    always #5 clk = ~clk;

    ctl_t dut_ctl;
    assign dut_ctl = {pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, dmem_wr,
                      dmem_r_addr_sel, dmem_w_addr_sel, rf_w_wr, rf_w_addr_sel,
                      rf_w_data_sel, rf_rp_addr_sel, temp_ld, nzp_ld, nzp_clr,
                      alu_sel, alu_in_a_sel, halted};

    // Model state: phase within the current instruction and retired count.
    int          m_step = c_INIT;
    logic [15:0] m_retire = 16'h0000;

    // Expectations for the cycle currently on the inputs.
    bit          chk_en = 1'b0;
    ctl_t        exp_ctl;
    logic [15:0] exp_ret;
    bit          lit_en = 1'b0;
    ctl_t        lit_val;
    string       lit_name;
    bit          lit_ret_en = 1'b0;
    logic [15:0] lit_ret;

    int n_checks = 0;
    int n_fail = 0;

    function automatic ctl_t model_ctl(input bit r, input int step,
                                       input logic [15:0] i, input bit nz);
        ctl_t c;
        logic [3:0] op;
        c  = '0;
        op = i[15:12];
        if (r || step == c_INIT) begin
            c.pc_clr = 1'b1; c.ir_clr = 1'b1; c.nzp_clr = 1'b1;
            return c;
        end
        if (step == c_FETCH) begin
            c.ir_ld = 1'b1; c.pc_inc = 1'b1;
        end else if (step == c_HALT) begin
            c.halted = 1'b1;
        end else if (step == c_EXEC) begin
            case (op)
                4'h1, 4'h5: begin
                    c.rf_rp_addr_sel = 1'b1; c.alu_in_a_sel = i[5];
                    c.alu_sel = (op == 4'h1) ? 2'b01 : 2'b10;
                    c.rf_w_wr = 1'b1; c.rf_w_addr_sel = 1'b1; c.nzp_ld = 1'b1;
                end
                4'h9: begin
                    c.alu_sel = 2'b11;
                    c.rf_w_wr = 1'b1; c.rf_w_addr_sel = 1'b1; c.nzp_ld = 1'b1;
                end
                4'h0: c.pc_ld = nz;
                4'hC: begin c.pc_ld = 1'b1; c.pc_sel = 2'b10; end
                4'h4: begin
                    c.rf_w_data_sel = 2'b11; c.rf_w_wr = 1'b1; c.pc_ld = 1'b1;
                    c.pc_sel = i[11] ? 2'b01 : 2'b10;
                end
                4'h2, 4'h6: begin
                    c.dmem_r_addr_sel = (op == 4'h2) ? 2'b01 : 2'b11;
                    c.rf_w_data_sel = 2'b10;
                    c.rf_w_wr = 1'b1; c.rf_w_addr_sel = 1'b1; c.nzp_ld = 1'b1;
                end
                4'hE: begin
                    c.rf_w_data_sel = 2'b01;
                    c.rf_w_wr = 1'b1; c.rf_w_addr_sel = 1'b1; c.nzp_ld = 1'b1;
                end
                4'h3: c.dmem_wr = 1'b1;
                4'h7: begin c.dmem_wr = 1'b1; c.dmem_w_addr_sel = 2'b10; end
                4'hA, 4'hB: begin c.dmem_r_addr_sel = 2'b01; c.temp_ld = 1'b1; end
                default: ;
            endcase
        end else if (step == c_EXEC2) begin
            if (op == 4'hA) begin
                c.dmem_r_addr_sel = 2'b10; c.rf_w_data_sel = 2'b10;
                c.rf_w_wr = 1'b1; c.rf_w_addr_sel = 1'b1; c.nzp_ld = 1'b1;
            end else begin
                c.dmem_wr = 1'b1; c.dmem_w_addr_sel = 2'b01;
            end
        end
        return c;
    endfunction

    // Compare process: every cycle with stimulus applied, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (dut_ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL ctl step=%0d ir=%h: got %h expected %h",
                         m_step, ir, dut_ctl, exp_ctl);
            end
            n_checks++;
            if (retire_count !== exp_ret) begin
                n_fail++;
                $display("FAIL retire_count step=%0d: got %h expected %h",
                         m_step, retire_count, exp_ret);
            end
            if (lit_en) begin
                n_checks++;
                if (dut_ctl !== lit_val) begin
                    n_fail++;
                    $display("FAIL pinned %s: got %h expected %h",
                             lit_name, dut_ctl, lit_val);
                end
            end
            if (lit_ret_en) begin
                n_checks++;
                if (retire_count !== lit_ret) begin
                    n_fail++;
                    $display("FAIL pinned retire_count: got %h expected %h",
                             retire_count, lit_ret);
                end
            end
        end
    end

    task automatic pin(input ctl_t v, input string nm);
        lit_en = 1'b1; lit_val = v; lit_name = nm;
    endtask

    task automatic pin_ret(input logic [15:0] v);
        lit_ret_en = 1'b1; lit_ret = v;
    endtask

    // Apply one cycle of inputs, then advance the model across the edge.
    task automatic tick(input bit r, input logic [15:0] i, input bit nz);
        rst = r; ir = i; nzp_match = nz;
        exp_ctl = model_ctl(r, m_step, i, nz);
        exp_ret = r ? 16'h0000 : m_retire;
        chk_en  = 1'b1;
        @(posedge clk);
        lit_en = 1'b0; lit_ret_en = 1'b0;
        if (r) begin
            m_step = c_INIT; m_retire = 16'h0000;
        end else begin
            case (m_step)
                c_INIT:   m_step = c_FETCH;
                c_FETCH:  m_step = c_DECODE;
                c_DECODE: m_step = (i[15:12] == 4'hF) ? c_HALT : c_EXEC;
                c_EXEC: begin
                    if (i[15:12] == 4'hA || i[15:12] == 4'hB) m_step = c_EXEC2;
                    else begin m_step = c_FETCH; m_retire = m_retire + 16'd1; end
                end
                c_EXEC2: begin m_step = c_FETCH; m_retire = m_retire + 16'd1; end
                default:  m_step = c_HALT;
            endcase
        end
        #1;
    endtask

    task automatic run_instr(input logic [15:0] i, input bit nz);
        tick(1'b0, i, nz);
        tick(1'b0, i, nz);
        if (i[15:12] != 4'hF) begin
            tick(1'b0, i, nz);
            if (i[15:12] == 4'hA || i[15:12] == 4'hB) tick(1'b0, i, nz);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset held two cycles, then INIT for exactly one.
        pin('{pc_clr: 1'b1, ir_clr: 1'b1, nzp_clr: 1'b1, default: '0}, "reset");
        pin_ret(16'h0000);
        tick(1'b1, 16'h0000, 1'b0);
        tick(1'b1, 16'h0000, 1'b0);
        pin('{pc_clr: 1'b1, ir_clr: 1'b1, nzp_clr: 1'b1, default: '0}, "init");
        tick(1'b0, 16'h0000, 1'b0);

        // ADD R1,R1,#1
        pin('{ir_ld: 1'b1, pc_inc: 1'b1, default: '0}, "fetch");
        pin_ret(16'h0000);
        tick(1'b0, 16'h1261, 1'b1);
        tick(1'b0, 16'h1261, 1'b1);
        pin('{rf_rp_addr_sel: 1'b1, alu_in_a_sel: 1'b1, alu_sel: 2'b01,
              rf_w_wr: 1'b1, rf_w_addr_sel: 1'b1, nzp_ld: 1'b1, default: '0},
            "add_exec");
        tick(1'b0, 16'h1261, 1'b1);

        pin_ret(16'h0001);
        run_instr(16'h5042, 1'b0);          // AND register form
        run_instr(16'h927F, 1'b1);          // NOT

        // BRnp not taken, then taken
        tick(1'b0, 16'h0A03, 1'b0);
        tick(1'b0, 16'h0A03, 1'b0);
        pin('0, "br_not_taken");
        tick(1'b0, 16'h0A03, 1'b0);
        tick(1'b0, 16'h0A03, 1'b1);
        tick(1'b0, 16'h0A03, 1'b1);
        pin('{pc_ld: 1'b1, default: '0}, "br_taken");
        tick(1'b0, 16'h0A03, 1'b1);

        run_instr(16'hC1C0, 1'b0);          // JMP R7
        run_instr(16'h4805, 1'b0);          // JSR off11

        // JSRR R7
        tick(1'b0, 16'h41C0, 1'b0);
        tick(1'b0, 16'h41C0, 1'b0);
        pin('{rf_w_wr: 1'b1, rf_w_data_sel: 2'b11, pc_ld: 1'b1, pc_sel: 2'b10,
              default: '0}, "jsrr_exec");
        tick(1'b0, 16'h41C0, 1'b0);

        run_instr(16'h2205, 1'b0);          // LD
        run_instr(16'h6245, 1'b1);          // LDR
        run_instr(16'hE20A, 1'b0);          // LEA
        run_instr(16'h3403, 1'b0);          // ST
        run_instr(16'h7441, 1'b0);          // STR
        run_instr(16'hA605, 1'b0);          // LDI

        // STI R2: four cycles
        tick(1'b0, 16'hB405, 1'b0);
        tick(1'b0, 16'hB405, 1'b0);
        pin('{temp_ld: 1'b1, dmem_r_addr_sel: 2'b01, default: '0}, "sti_exec");
        tick(1'b0, 16'hB405, 1'b0);
        pin('{dmem_wr: 1'b1, dmem_w_addr_sel: 2'b01, default: '0}, "sti_exec2");
        tick(1'b0, 16'hB405, 1'b0);

        run_instr(16'hD000, 1'b1);          // reserved -> NOP

        // ST aborted by reset in its execute cycle: no write strobe.
        pin_ret(16'd16);
        tick(1'b0, 16'h3403, 1'b0);
        tick(1'b0, 16'h3403, 1'b0);
        pin('{pc_clr: 1'b1, ir_clr: 1'b1, nzp_clr: 1'b1, default: '0}, "abort_st");
        tick(1'b1, 16'h3403, 1'b0);
        tick(1'b0, 16'h3403, 1'b0);         // INIT

        run_instr(16'h1261, 1'b0);
        run_instr(16'h5062, 1'b0);          // AND immediate form

        // HALT: absorbing for 20 cycles, count frozen
        tick(1'b0, 16'hF025, 1'b0);
        tick(1'b0, 16'hF025, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (k == 10) begin
                pin('{halted: 1'b1, default: '0}, "halt");
                pin_ret(16'd2);
            end
            tick(1'b0, 16'hF025, k[0]);
        end

        // Reset leaves HALT and clears the count
        tick(1'b1, 16'hF025, 1'b0);
        tick(1'b0, 16'h0000, 1'b0);
        pin_ret(16'h0000);
        pin('{ir_ld: 1'b1, pc_inc: 1'b1, default: '0}, "fetch_after_halt");
        tick(1'b0, 16'h1261, 1'b0);

        chk_en = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
